// File: rtl/pa_fdsu_seq_ctrl_if.sv
// pa_fdsu_seq_ctrl_if: issue, prepare, SRT, round and write-back signals of the
// FDSU sequencing controller. The slave modport is the controller, the master
// modport is the surrounding pipeline.
interface pa_fdsu_seq_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             idu_fdsu_ex1_vld;
  logic [1:0]       idu_fdsu_ex1_func;
  logic             ex1_op0_id;
  logic             ex1_op1_id;
  logic             ex1_special_vld;
  logic             rtu_fdsu_flush;
  logic             wb_fdsu_ready;
  logic             fdsu_idu_ready;
  logic             fdsu_ex1_sel;
  logic             ex1_op1_sel;
  logic             ex1_id_latch_en;
  logic             ex1_stall;
  logic             srt_load;
  logic             srt_iter_vld;
  logic [CNT_W-1:0] srt_iter_cnt;
  logic             rnd_vld;
  logic             fdsu_wb_vld;
  logic             fdsu_wb_div;
  logic             fdsu_wb_special;
  logic             fdsu_busy;

  modport slave (
    input  idu_fdsu_ex1_vld, idu_fdsu_ex1_func, ex1_op0_id, ex1_op1_id,
           ex1_special_vld, rtu_fdsu_flush, wb_fdsu_ready,
    output fdsu_idu_ready, fdsu_ex1_sel, ex1_op1_sel, ex1_id_latch_en,
           ex1_stall, srt_load, srt_iter_vld, srt_iter_cnt, rnd_vld,
           fdsu_wb_vld, fdsu_wb_div, fdsu_wb_special, fdsu_busy
  );

  modport master (
    output idu_fdsu_ex1_vld, idu_fdsu_ex1_func, ex1_op0_id, ex1_op1_id,
           ex1_special_vld, rtu_fdsu_flush, wb_fdsu_ready,
    input  fdsu_idu_ready, fdsu_ex1_sel, ex1_op1_sel, ex1_id_latch_en,
           ex1_stall, srt_load, srt_iter_vld, srt_iter_cnt, rnd_vld,
           fdsu_wb_vld, fdsu_wb_div, fdsu_wb_special, fdsu_busy
  );
endinterface

// File: rtl/pa_fdsu_seq_ctrl.sv
// pa_fdsu_seq_ctrl: FDSU div/sqrt sequencer. Accepts an issue, runs the optional
// second denormal-normalisation pass, counts SRT iterations, strobes rounding
// and holds the result for write-back.
// Optional feature macro: FDSU_SPECIAL_BYPASS_EN (special results skip straight
// to write-back the cycle after accept).
module pa_fdsu_seq_ctrl #(
  parameter int unsigned ITER_NUM = 13,
  parameter int unsigned CNT_W    = 4
) (
  input logic                forever_cpuclk,
  input logic                cpurst,
  pa_fdsu_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ID1  = 3'd1,
    ST_ITER = 3'd2,
    ST_RND  = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             spec_q, spec_d;

  logic             func_ok;
  logic             is_div;
  logic             accept;
  logic             both_id;
  logic             bypass_req;
  logic             kill;

  logic             ex1_sel_c;
  logic             op1_sel_c;
  logic             latch_en_c;
  logic             stall_c;
  logic             srt_load_c;
  logic             iter_vld_c;
  logic             rnd_vld_c;
  logic             wb_vld_c;

  // Issue qualification: exactly one of {div, sqrt} requested
  assign func_ok = bus.idu_fdsu_ex1_func[1] ^ bus.idu_fdsu_ex1_func[0];
  assign is_div  = bus.idu_fdsu_ex1_func[1];
  assign kill    = bus.rtu_fdsu_flush | cpurst;
  assign accept  = bus.idu_fdsu_ex1_vld & (state_q == ST_IDLE) & func_ok & ~kill;

`ifdef FDSU_SPECIAL_BYPASS_EN
  assign bypass_req = bus.ex1_special_vld;
`else
  assign bypass_req = 1'b0;
`endif

  // Only a divide with both operands denormal needs the second prepare pass
  assign both_id = is_div & bus.ex1_op0_id & bus.ex1_op1_id & ~bypass_req;

  // State, iteration counter and latched op flags
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      spec_q  <= spec_d;
    end
  end

  // Next state and per-cycle strobes; flush or reset suppresses every strobe
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    spec_d     = spec_q;
    ex1_sel_c  = 1'b0;
    op1_sel_c  = 1'b0;
    latch_en_c = 1'b0;
    stall_c    = 1'b0;
    srt_load_c = 1'b0;
    iter_vld_c = 1'b0;
    rnd_vld_c  = 1'b0;
    wb_vld_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ex1_sel_c = 1'b1;
          div_d     = is_div;
          spec_d    = bus.ex1_special_vld;
          if (bypass_req) begin
            state_d = ST_WB;
          end else if (both_id) begin
            // First pass normalises op0; op1 follows in ID1
            latch_en_c = 1'b1;
            stall_c    = 1'b1;
            state_d    = ST_ID1;
          end else begin
            op1_sel_c  = is_div & bus.ex1_op1_id;
            srt_load_c = 1'b1;
            cnt_d      = CNT_INIT;
            state_d    = ST_ITER;
          end
        end
      end
      ST_ID1: begin
        ex1_sel_c  = 1'b1;
        op1_sel_c  = 1'b1;
        srt_load_c = 1'b1;
        cnt_d      = CNT_INIT;
        state_d    = ST_ITER;
      end
      ST_ITER: begin
        iter_vld_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RND: begin
        rnd_vld_c = 1'b1;
        state_d   = ST_WB;
      end
      ST_WB: begin
        wb_vld_c = 1'b1;
        if (bus.wb_fdsu_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (kill) begin
      state_d    = ST_IDLE;
      cnt_d      = cnt_q;
      div_d      = div_q;
      spec_d     = spec_q;
      ex1_sel_c  = 1'b0;
      op1_sel_c  = 1'b0;
      latch_en_c = 1'b0;
      stall_c    = 1'b0;
      srt_load_c = 1'b0;
      iter_vld_c = 1'b0;
      rnd_vld_c  = 1'b0;
      wb_vld_c   = 1'b0;
    end
  end

  // Output drive
  assign bus.fdsu_idu_ready  = (state_q == ST_IDLE);
  assign bus.fdsu_busy       = (state_q != ST_IDLE);
  assign bus.fdsu_ex1_sel    = ex1_sel_c;
  assign bus.ex1_op1_sel     = op1_sel_c;
  assign bus.ex1_id_latch_en = latch_en_c;
  assign bus.ex1_stall       = stall_c;
  assign bus.srt_load        = srt_load_c;
  assign bus.srt_iter_vld    = iter_vld_c;
  assign bus.srt_iter_cnt    = cnt_q;
  assign bus.rnd_vld         = rnd_vld_c;
  assign bus.fdsu_wb_vld     = wb_vld_c;
  assign bus.fdsu_wb_div     = div_q;
  assign bus.fdsu_wb_special = spec_q;

endmodule

// File: tb/tb_pa_fdsu_seq_ctrl.sv
// tb_pa_fdsu_seq_ctrl: directed latency scenarios plus randomized traffic,
// checked every cycle against a cycle-count model of one in-flight operation.
module tb_pa_fdsu_seq_ctrl;

  localparam int ITER  = 13;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic cpurst;

  always #5 clk = ~clk;

  pa_fdsu_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pa_fdsu_seq_ctrl #(.ITER_NUM(ITER), .CNT_W(CNT_W)) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .bus            (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: is an op in flight, cycles since its accept, extra ID1 cycle, bypass, latched flags
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_d    = 0;
  bit m_byp  = 1'b0;
  bit m_div  = 1'b0;
  bit m_spec = 1'b0;

  // Last observed DUT outputs, for the directed literal checks
  bit obs_wb, obs_busy, obs_ready, obs_div, obs_spec, obs_strobe;
  int obs_cnt;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive, check against the model, advance the model at the edge
  task automatic step(input bit vld, input bit [1:0] func, input bit op0, input bit op1,
                      input bit spec, input bit fl, input bit rdy, input bit rst);
    bit div_req, acc, byp_req, both, id1, iterp, rndp, wbp;
    bus.idu_fdsu_ex1_vld  = vld;
    bus.idu_fdsu_ex1_func = func;
    bus.ex1_op0_id        = op0;
    bus.ex1_op1_id        = op1;
    bus.ex1_special_vld   = spec;
    bus.rtu_fdsu_flush    = fl;
    bus.wb_fdsu_ready     = rdy;
    cpurst                = rst;
    #4;
    div_req = (func == 2'b10);
    acc     = !m_busy && vld && (func == 2'b01 || func == 2'b10) && !fl && !rst;
`ifdef FDSU_SPECIAL_BYPASS_EN
    byp_req = spec;
`else
    byp_req = 1'b0;
`endif
    both  = div_req && op0 && op1 && !byp_req;
    id1   = m_busy && !m_byp && m_d == 1 && m_k == 1;
    iterp = m_busy && !m_byp && m_k >= 1 + m_d && m_k <= ITER + m_d;
    rndp  = m_busy && !m_byp && m_k == ITER + 1 + m_d;
    wbp   = m_busy && (m_byp || m_k >= ITER + 2 + m_d);

    obs_wb     = bus.fdsu_wb_vld;
    obs_busy   = bus.fdsu_busy;
    obs_ready  = bus.fdsu_idu_ready;
    obs_div    = bus.fdsu_wb_div;
    obs_spec   = bus.fdsu_wb_special;
    obs_cnt    = int'(bus.srt_iter_cnt);
    obs_strobe = bus.fdsu_ex1_sel | bus.ex1_op1_sel | bus.ex1_id_latch_en | bus.ex1_stall |
                 bus.srt_load | bus.srt_iter_vld | bus.rnd_vld | bus.fdsu_wb_vld;

    if (!rst) begin
      chk("idu_ready", int'(bus.fdsu_idu_ready), int'(!m_busy));
      chk("busy", int'(bus.fdsu_busy), int'(m_busy));
      chk("ex1_sel", int'(bus.fdsu_ex1_sel), int'(acc || (id1 && !fl)));
      chk("op1_sel", int'(bus.ex1_op1_sel),
          acc ? int'(div_req && op1 && !both && !byp_req) : int'(id1 && !fl));
      chk("latch_en", int'(bus.ex1_id_latch_en), int'(acc && both));
      chk("stall", int'(bus.ex1_stall), int'(acc && both));
      chk("srt_load", int'(bus.srt_load), int'((acc && !both && !byp_req) || (id1 && !fl)));
      chk("iter_vld", int'(bus.srt_iter_vld), int'(iterp && !fl));
      if (iterp && !fl) chk("iter_cnt", obs_cnt, ITER + m_d - m_k);
      chk("rnd_vld", int'(bus.rnd_vld), int'(rndp && !fl));
      chk("wb_vld", int'(bus.fdsu_wb_vld), int'(wbp && !fl));
      if (wbp && !fl) begin
        chk("wb_div", int'(bus.fdsu_wb_div), int'(m_div));
        chk("wb_special", int'(bus.fdsu_wb_special), int'(m_spec));
      end
    end

    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_div = 1'b0; m_spec = 1'b0;
    end else if (fl) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (acc) begin
        m_busy = 1'b1; m_k = 1; m_d = both ? 1 : 0;
        m_byp = byp_req; m_div = div_req; m_spec = spec;
      end
    end else if (wbp && rdy) begin
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Issue one op; keep re-issuing while busy; hold ready low for `hold` WB cycles
  task automatic run_op(input string name, input bit [1:0] func, input bit op0, input bit op1,
                        input bit spec, input int hold, input int exp_first, input int exp_len);
    int first, len;
    bit done, rdy, sp_seen;
    first = -1; len = 0; done = 1'b0; sp_seen = 1'b0;
    step(1'b1, func, op0, op1, spec, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 60 && !done; c++) begin
      rdy = (len >= hold);
      step(1'b1, func, op0, op1, spec, 1'b0, rdy, 1'b0);
      if (obs_wb) begin
        if (first < 0) begin first = c; sp_seen = obs_spec; end
        len++;
        if (rdy) done = 1'b1;
      end
    end
    chk({name, "_done"}, int'(done), 1);
    chk({name, "_first_wb"}, first, exp_first);
    chk({name, "_wb_len"}, len, exp_len);
    chk({name, "_wb_special"}, int'(sp_seen), int'(spec));
    idle_step();
    chk({name, "_ready_after"}, int'(obs_ready), 1);
  endtask

  initial begin
    int wb_seen;
    bus.idu_fdsu_ex1_vld  = 1'b0;
    bus.idu_fdsu_ex1_func = 2'b00;
    bus.ex1_op0_id        = 1'b0;
    bus.ex1_op1_id        = 1'b0;
    bus.ex1_special_vld   = 1'b0;
    bus.rtu_fdsu_flush    = 1'b0;
    bus.wb_fdsu_ready     = 1'b0;
    cpurst                = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_step();
    chk("reset_ready", int'(obs_ready), 1);
    chk("reset_cnt", obs_cnt, 0);
    chk("reset_flags", int'(obs_div | obs_spec | obs_strobe), 0);

    // Invalid func encodings are ignored
    step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bad_func_idle", int'(obs_busy), 0);

    run_op("div_norm", 2'b10, 1'b0, 1'b0, 1'b0, 0, 15, 1);
    run_op("div_both_id", 2'b10, 1'b1, 1'b1, 1'b0, 0, 16, 1);
    run_op("sqrt_op1_id", 2'b01, 1'b0, 1'b1, 1'b0, 0, 15, 1);
    run_op("div_wb_hold", 2'b10, 1'b0, 1'b1, 1'b0, 3, 15, 4);
`ifdef FDSU_SPECIAL_BYPASS_EN
    run_op("div_special", 2'b10, 1'b1, 1'b1, 1'b1, 0, 1, 1);
`else
    run_op("div_special", 2'b10, 1'b1, 1'b1, 1'b1, 0, 16, 1);
`endif

    // Flush at cycle 7 with a simultaneous issue attempt
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 7; c++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wb_seen = 0;
    idle_step();
    chk("flush_idle", int'(obs_busy), 0);
    for (int c = 0; c < 20; c++) begin
      idle_step();
      if (obs_wb) wb_seen++;
    end
    chk("flush_no_wb", wb_seen, 0);

    // Reset at cycle 5 of a divide
    step(1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 5; c++) idle_step();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_step();
    chk("rst_mid_idle", int'(obs_busy), 0);
    chk("rst_mid_ready", int'(obs_ready), 1);
    chk("rst_mid_cnt", obs_cnt, 0);
    chk("rst_mid_outs", int'(obs_div | obs_spec | obs_strobe), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 4) < 3, $urandom_range(0, 149) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
